ts_sync_aligner: RTL and testbench

TS_SYNC_ALIGNER -- requirements
Module: ts_sync_aligner

---
 rtl/ts_pkg.sv | 31 +++
 rtl/ts_sync_aligner.sv | 176 +++++++++++++++++
 tb/tb_ts_sync_aligner.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ts_pkg.sv
// ---------------------------------------------------------------------------
// ts_pkg -- shared constants and types for the MPEG-TS sync aligner.
//   TS_SYNC_BYTE : transport-stream sync byte value (0x47)
//   TS_PKT_LEN   : packet length in bytes (188)
//   TS_LAST_POS  : byte position of the last byte in a packet (187)
//   ts_state_e   : aligner FSM state encoding (HUNT / VERIFY / LOCKED)
//   next_pos()   : byte-position increment with 187 -> 0 wrap
// ---------------------------------------------------------------------------
package ts_pkg;

  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         TS_PKT_LEN   = 188;
  localparam logic [7:0] TS_LAST_POS  = 8'd187;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } ts_state_e;

  function automatic logic [7:0] next_pos(input logic [7:0] pos);
    logic [7:0] nxt;
    if (pos == TS_LAST_POS) begin
      nxt = 8'd0;
    end else begin
      nxt = pos + 8'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ts_sync_aligner.sv
// ---------------------------------------------------------------------------
// ts_sync_aligner -- finds 188-byte MPEG-TS packet alignment in a byte stream
// read from a FIFO and re-emits aligned packets with framing flags.
//
// Ports:
//   clk       in   single clock (FIFO read side)
//   rst       in   synchronous, active-high reset
//   rdata     in   [7:0] byte from FIFO read port (valid the cycle after ren)
//   rempty    in   FIFO empty flag
//   ren       out  FIFO read enable (= ~rempty & ~rst, no backpressure)
//   out_data  out  [7:0] aligned TS byte
//   out_valid out  out_data valid this cycle
//   out_sop   out  first byte of packet (position 0)
//   out_eop   out  last byte of packet (position 187)
//   out_err   out  with out_sop: this packet's sync byte was not 0x47
//   locked    out  aligner is in LOCKED
//   loss_cnt  out  [15:0] lock-loss events, saturating
//
// Parameters:
//   LOCK_CNT  sync bytes at 188-byte spacing needed to lock
//   LOSS_CNT  consecutive missing sync bytes that drop lock
// ---------------------------------------------------------------------------
module ts_sync_aligner
  import ts_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rdata,
  input  logic        rempty,
  output logic        ren,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_err,
  output logic        locked,
  output logic [15:0] loss_cnt
);

  localparam logic [15:0] LOCK_TGT = 16'(LOCK_CNT);
  localparam logic [15:0] LOSS_TGT = 16'(LOSS_CNT);

  ts_state_e   state_r;
  logic [7:0]  pos_r;
  logic [15:0] hits_r;
  logic [15:0] misses_r;
  // High in the cycle rdata carries a byte read on the previous edge.
  logic        accept_r;

  // FIFO read enable: read whenever data is present and not in reset.
  assign ren = ~rempty & ~rst;

  // Alignment FSM, position/hit/miss counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_HUNT;
      pos_r     <= 8'd0;
      hits_r    <= 16'd0;
      misses_r  <= 16'd0;
      accept_r  <= 1'b0;
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_err   <= 1'b0;
      locked    <= 1'b0;
      loss_cnt  <= 16'd0;
    end else begin
      // Flags are single-cycle; only an emitted byte raises them.
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_err   <= 1'b0;
      accept_r  <= ren;
      // No accepted byte means a stall: position and state hold.
      if (accept_r) begin
        case (state_r)
          ST_HUNT: begin
            if (rdata == TS_SYNC_BYTE) begin
              hits_r <= 16'd1;
              pos_r  <= 8'd1;
              if (LOCK_TGT <= 16'd1) begin
                state_r   <= ST_LOCKED;
                locked    <= 1'b1;
                misses_r  <= 16'd0;
                out_data  <= rdata;
                out_valid <= 1'b1;
                out_sop   <= 1'b1;
              end else begin
                state_r <= ST_VERIFY;
              end
            end else begin
              pos_r <= 8'd0;
            end
          end

          ST_VERIFY: begin
            pos_r <= next_pos(pos_r);
            if (pos_r == 8'd0) begin
              if (rdata == TS_SYNC_BYTE) begin
                hits_r <= hits_r + 16'd1;
                if (hits_r + 16'd1 >= LOCK_TGT) begin
                  // This sync byte completes the lock and starts output.
                  state_r   <= ST_LOCKED;
                  locked    <= 1'b1;
                  misses_r  <= 16'd0;
                  out_data  <= rdata;
                  out_valid <= 1'b1;
                  out_sop   <= 1'b1;
                end else begin
                  state_r <= ST_VERIFY;
                end
              end else begin
                // Failed candidate: the offending byte is consumed, not rescanned.
                state_r <= ST_HUNT;
                hits_r  <= 16'd0;
                pos_r   <= 8'd0;
              end
            end else begin
              state_r <= ST_VERIFY;
            end
          end

          ST_LOCKED: begin
            pos_r <= next_pos(pos_r);
            if (pos_r == 8'd0) begin
              if (rdata == TS_SYNC_BYTE) begin
                misses_r  <= 16'd0;
                out_data  <= rdata;
                out_valid <= 1'b1;
                out_sop   <= 1'b1;
              end else if (misses_r + 16'd1 < LOSS_TGT) begin
                // Tolerated miss: forward the packet flagged as errored.
                misses_r  <= misses_r + 16'd1;
                out_data  <= rdata;
                out_valid <= 1'b1;
                out_sop   <= 1'b1;
                out_err   <= 1'b1;
              end else begin
                // Final miss: drop this byte and go back to hunting.
                state_r  <= ST_HUNT;
                locked   <= 1'b0;
                pos_r    <= 8'd0;
                hits_r   <= 16'd0;
                misses_r <= 16'd0;
                if (loss_cnt != 16'hFFFF) begin
                  loss_cnt <= loss_cnt + 16'd1;
                end else begin
                  loss_cnt <= loss_cnt;
                end
              end
            end else begin
              out_data  <= rdata;
              out_valid <= 1'b1;
              out_eop   <= (pos_r == TS_LAST_POS);
            end
          end

          default: begin
            state_r  <= ST_HUNT;
            locked   <= 1'b0;
            pos_r    <= 8'd0;
            hits_r   <= 16'd0;
            misses_r <= 16'd0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_ts_sync_aligner.sv
// ---------------------------------------------------------------------------
// tb_ts_sync_aligner -- scoreboard bench for ts_sync_aligner. The bench plays
// the FIFO (rdata one cycle after ren), a stream-level reference model turns
// each byte stream into the expected output sequence, and a monitor compares
// every emitted byte against the head of the expectation queue.
// ---------------------------------------------------------------------------
module tb_ts_sync_aligner;

  localparam int LOCK_N = 3;
  localparam int LOSS_N = 3;
  localparam int PLEN   = 188;
  localparam logic [7:0] SYNC = 8'h47;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rdata = 8'd0;
  logic        rempty = 1'b1;
  logic        ren;
  logic [7:0]  out_data;
  logic        out_valid, out_sop, out_eop, out_err, locked;
  logic [15:0] loss_cnt;

  int   checks = 0;
  int   failures = 0;
  int   out_count = 0;
  exp_t exp_q[$];
  bq_t  src_q;
  bq_t  saved_q;
  bit   exp_lk;
  int   exp_loss;
  bit   did_rst;

  ts_sync_aligner #(.LOCK_CNT(LOCK_N), .LOSS_CNT(LOSS_N)) dut (
    .clk(clk), .rst(rst), .rdata(rdata), .rempty(rempty), .ren(ren),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop),
    .out_eop(out_eop), .out_err(out_err), .locked(locked), .loss_cnt(loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: scan the whole stream by index using the alignment rules.
  task automatic model(input bq_t s, output bit lk, output int loss);
    int   i, j, k, n, p, misses;
    bit   ok, bad;
    exp_t e;
    n = s.size(); i = 0; lk = 1'b0; loss = 0;
    while (i < n) begin
      if (s[i] != SYNC) begin
        i++;
        continue;
      end
      ok = 1'b1;
      for (k = 1; k < LOCK_N; k++) begin
        j = i + k * PLEN;
        if (j >= n) begin ok = 1'b0; i = n; break; end
        if (s[j] != SYNC) begin ok = 1'b0; i = j + 1; break; end
      end
      if (!ok) continue;
      p = i + (LOCK_N - 1) * PLEN;
      misses = 0;
      lk = 1'b1;
      while (p < n) begin
        bad = (s[p] != SYNC);
        if (bad) begin
          misses++;
          if (misses == LOSS_N) begin
            lk = 1'b0;
            loss++;
            break;
          end
        end else begin
          misses = 0;
        end
        for (k = 0; k < PLEN && p + k < n; k++) begin
          e.d = s[p + k]; e.sop = (k == 0); e.eop = (k == PLEN - 1); e.err = (k == 0) && bad;
          exp_q.push_back(e);
        end
        p += PLEN;
      end
      i = p + 1;
    end
  endtask

  task automatic add_pkt(input logic [7:0] sync, input int base, input bit rnd);
    src_q.push_back(sync);
    for (int k = 1; k < PLEN; k++) begin
      if (rnd) src_q.push_back(8'($urandom_range(0, 255)));
      else     src_q.push_back(8'((base + k) & 255));
    end
  endtask

  // Assert reset from the current (post-negedge) point and check cleared state.
  task automatic do_reset();
    rst = 1'b1;
    rempty = 1'b1;
    #1;
    chk("ren_in_reset", ren, 0);
    @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sop", out_sop, 0);
    chk("rst_out_eop", out_eop, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_locked", locked, 0);
    chk("rst_loss_cnt", loss_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    src_q.delete();
    out_count = 0;
  endtask

  // Act as the FIFO: present the next byte the cycle after ren was high.
  task automatic feed(input bit stall, input int rst_after, output bit rst_hit);
    int guard;
    bit take;
    guard = 0;
    rst_hit = 1'b0;
    while (src_q.size() > 0 && guard < 30000) begin
      @(negedge clk); #2;
      if (rst_after >= 0 && out_count >= rst_after) begin
        rst_hit = 1'b1;
        break;
      end
      rempty = stall ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      take = ren;
      chk("ren_vs_rempty", ren, !rempty);
      @(posedge clk); #1;
      if (take) rdata = src_q.pop_front();
      guard++;
    end
    rempty = 1'b1;
    if (guard >= 30000) begin
      failures++;
      $display("FAIL feed_timeout actual=%0d required=<30000", guard);
    end
  endtask

  task automatic drain_and_check(input string tag);
    repeat (12) @(negedge clk);
    chk({tag, "_exp_left"}, exp_q.size(), 0);
    chk({tag, "_locked"}, locked, exp_lk);
    chk({tag, "_loss_cnt"}, loss_cnt, exp_loss);
  endtask

  // Monitor: compare each presented byte with the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      out_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out actual=byte_%0h_sop%0b_eop%0b required=no_output",
                 out_data, out_sop, out_eop);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_sop", out_sop, e.sop);
        chk("out_eop", out_eop, e.eop);
        chk("out_err", out_err, e.err);
        chk("locked_while_valid", locked, 1);
      end
    end else begin
      chk("idle_flags", {out_sop, out_eop, out_err}, 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout actual=expired required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    // Clean stream: lock on the third sync.
    do_reset();
    for (int p = 0; p < 5; p++) add_pkt(SYNC, p * 3, 1'b0);
    model(src_q, exp_lk, exp_loss);
    feed(1'b0, -1, did_rst);
    drain_and_check("clean");

    // Garbage prefix before a clean stream.
    do_reset();
    src_q.push_back(8'h00); src_q.push_back(8'h12); src_q.push_back(8'hA5);
    for (int p = 0; p < 5; p++) add_pkt(SYNC, p * 11, 1'b0);
    model(src_q, exp_lk, exp_loss);
    feed(1'b0, -1, did_rst);
    drain_and_check("garbage");

    // Isolated bad syncs: errored packets, misses clear on good sync.
    do_reset();
    add_pkt(SYNC, 0, 1'b0); add_pkt(SYNC, 1, 1'b0); add_pkt(SYNC, 2, 1'b0);
    add_pkt(8'h00, 3, 1'b0); add_pkt(SYNC, 4, 1'b0);
    add_pkt(8'h00, 5, 1'b0); add_pkt(8'h13, 6, 1'b0); add_pkt(SYNC, 7, 1'b0);
    model(src_q, exp_lk, exp_loss);
    feed(1'b0, -1, did_rst);
    drain_and_check("bad_sync");

    // Three consecutive bad syncs drop lock.
    do_reset();
    for (int p = 0; p < 4; p++) add_pkt(SYNC, p, 1'b0);
    for (int p = 0; p < 3; p++) add_pkt(8'h00, 40 + p, 1'b0);
    add_pkt(SYNC, 90, 1'b0); add_pkt(SYNC, 91, 1'b0);
    model(src_q, exp_lk, exp_loss);
    feed(1'b0, -1, did_rst);
    drain_and_check("loss");

    // Random payload, unstalled then the same stream with 50% empty stalls.
    do_reset();
    for (int g = $urandom_range(0, 40); g > 0; g--) src_q.push_back(8'($urandom_range(0, 255)));
    for (int p = 0; p < 10; p++) add_pkt(($urandom_range(0, 9) == 0) ? 8'h00 : SYNC, 0, 1'b1);
    saved_q = src_q;
    model(src_q, exp_lk, exp_loss);
    feed(1'b0, -1, did_rst);
    drain_and_check("rand_nostall");
    do_reset();
    src_q = saved_q;
    model(src_q, exp_lk, exp_loss);
    feed(1'b1, -1, did_rst);
    drain_and_check("rand_stall");

    // Reset at byte 100 of a locked packet, then relock on a fresh stream.
    do_reset();
    for (int p = 0; p < 6; p++) add_pkt(SYNC, p * 5, 1'b0);
    model(src_q, exp_lk, exp_loss);
    feed(1'b0, PLEN + 100, did_rst);
    chk("mid_rst_reached", did_rst, 1);
    do_reset();
    repeat (5) @(negedge clk);
    for (int p = 0; p < 5; p++) add_pkt(SYNC, p * 9, 1'b0);
    model(src_q, exp_lk, exp_loss);
    feed(1'b0, -1, did_rst);
    drain_and_check("relock");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
